// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-requester data-memory arbiter.
// Holds the default depth, requester index type and response tag.
package dmem_arbiter_pkg;

    localparam int DEPTH_DEFAULT = 32;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

    typedef struct packed {
        logic     valid;
        req_idx_e owner;
        logic     err;
    } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant from req and pointer.
// Lone requesters win outright; the pointer only breaks ties.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between
// a core and a DMA/debug port, with a 1-cycle read response path.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    input  logic [31:0]   mem_dout
);

    logic [1:0] req;
    logic [1:0] gnt;
    req_idx_e   ptr_q, ptr_d;
    rsp_tag_t   tag_q, tag_d;
    logic       sel_we;
    logic       in_range;

    // Requests are masked in reset so no grant can leak out.
    assign req = {req1, req0} & {2{~rst}};

    rr_pick2 u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_comb begin
        mem_addr = gnt[1] ? addr1 : addr0;
        mem_din  = gnt[1] ? wdata1 : wdata0;
        sel_we   = gnt[1] ? we1 : we0;
        in_range = mem_addr < AW'(DEPTH);
        mem_we   = (|gnt) & sel_we & in_range;

        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = REQ1;
        end else if (gnt[1]) begin
            ptr_d = REQ0;
        end

        tag_d = '0;
        if (|gnt) begin
            tag_d.valid = ~sel_we;
            tag_d.owner = gnt[1] ? REQ1 : REQ0;
            tag_d.err   = ~in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ0;
            tag_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
        end
    end

    // Gating with rst drops a response that was in flight at reset.
    always_comb begin
        rvalid0 = ~rst & tag_q.valid & (tag_q.owner == REQ0);
        rvalid1 = ~rst & tag_q.valid & (tag_q.owner == REQ1);
        err0    = ~rst & tag_q.err & (tag_q.owner == REQ0);
        err1    = ~rst & tag_q.err & (tag_q.owner == REQ1);
        rdata0  = (rvalid0 & ~tag_q.err) ? mem_dout : 32'h0;
        rdata1  = (rvalid1 & ~tag_q.err) ? mem_dout : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of grants and memory.
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic          mem_we;
    logic [31:0]   mem_dout;

    logic [31:0] tb_mem [0:DEPTH-1] = '{default: 32'h0};

    always #5 clk = ~clk;

    // Synchronous memory fixture with registered read data
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[4:0]] <= mem_din;
        mem_dout <= tb_mem[mem_addr[4:0]];
    end

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .err0     (err0),
        .err1     (err1),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int          m_ptr;
    logic [31:0] model_mem [DEPTH];
    logic        e_rv  [2];
    logic        e_err [2];
    logic [31:0] e_rd  [2];
    logic        g0, g1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r,
                        input logic q0, input logic w0,
                        input logic [AW-1:0] a0, input logic [31:0] d0,
                        input logic q1, input logic w1,
                        input logic [AW-1:0] a1, input logic [31:0] d1);
        int win;
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        @(negedge clk);
        rst = r;
        req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        win = -1;
        if (!r) begin
            if (q0 && q1) win = m_ptr;
            else if (q0) win = 0;
            else if (q1) win = 1;
        end
        w = (win == 1) ? w1 : w0;
        a = (win == 1) ? a1 : a0;
        d = (win == 1) ? d1 : d0;
        chk("gnt0", gnt0, win == 0);
        chk("gnt1", gnt1, win == 1);
        chk("mem_we", mem_we, win >= 0 && w && a < DEPTH);
        if (win >= 0) chk("mem_addr", mem_addr, a);
        if (win >= 0 && w && a < DEPTH) chk("mem_din", mem_din, d);
        chk("rvalid0", rvalid0, !r && e_rv[0]);
        chk("rvalid1", rvalid1, !r && e_rv[1]);
        chk("err0", err0, !r && e_err[0]);
        chk("err1", err1, !r && e_err[1]);
        if (!r && e_rv[0]) chk("rdata0", rdata0, e_rd[0]);
        if (!r && e_rv[1]) chk("rdata1", rdata1, e_rd[1]);
        g0 = (win == 0);
        g1 = (win == 1);
        for (int i = 0; i < 2; i++) begin
            e_rv[i] = 1'b0; e_err[i] = 1'b0; e_rd[i] = 32'h0;
        end
        if (r) begin
            m_ptr = 0;
        end else if (win >= 0) begin
            m_ptr = 1 - win;
            if (a >= DEPTH) begin
                e_err[win] = 1'b1;
                e_rv[win]  = !w;
            end else if (w) begin
                model_mem[a] = d;
            end else begin
                e_rv[win] = 1'b1;
                e_rd[win] = model_mem[a];
            end
        end
    endtask

    initial begin
        logic          r0, r1, w0r, w1r;
        logic [AW-1:0] a0r, a1r;
        logic [31:0]   d0r, d1r;
        m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            e_rv[i] = 1'b0; e_err[i] = 1'b0; e_rd[i] = 32'h0;
        end
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset with both requesting, then contention
        step(1, 1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0);
        chk("first_gnt0", gnt0, 1'b1);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0);
        chk("alt_gnt1", gnt1, 1'b1);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write then read back from the other requester
        step(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wr_rd_data", rdata1, 32'hDEADBEEF);

        // Out-of-range read and write
        step(0, 0, 0, 0, 0, 1, 0, 40, 0);
        step(0, 0, 0, 0, 0, 1, 1, 33, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pipelined reads
        step(0, 1, 1, 1, 32'h11, 0, 0, 0, 0);
        step(0, 1, 1, 2, 32'h22, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset right after a read grant
        step(0, 1, 0, 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; a losing request holds its payload
        r0 = 0; r1 = 0; w0r = 0; w1r = 0;
        a0r = 0; a1r = 0; d0r = 0; d1r = 0;
        g0 = 0; g1 = 0;
        for (int n = 0; n < 500; n++) begin
            logic rr;
            rr = ($urandom_range(0, 39) == 0);
            if (!r0 || g0) begin
                r0  = ($urandom_range(0, 3) != 0);
                w0r = $urandom_range(0, 1) == 1;
                a0r = AW'($urandom_range(0, 39));
                d0r = $urandom;
            end
            if (!r1 || g1) begin
                r1  = ($urandom_range(0, 3) != 0);
                w1r = $urandom_range(0, 1) == 1;
                a1r = AW'($urandom_range(0, 39));
                d1r = $urandom;
            end
            step(rr, r0, w0r, a0r, d0r, r1, w1r, a1r, d1r);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 32: number of implemented memory words; legal word addresses are 0..DEPTH-1.
REQ-002 Parameter AW, default 32: address width of requester and memory ports.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0, req1  input  1 each  access request from requester 0 (core) and requester 1 (DMA/debug).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN=1.
REQ-007 addr0, addr1  input  AW each  word address; valid while reqN=1.
REQ-008 wdata0, wdata1  input  32 each  write data; valid while reqN=1 and weN=1.
REQ-009 gnt0, gnt1  output  1 each  combinational accept, same cycle as the request; the request is consumed on that clock edge.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle read-response strobe.
REQ-011 rdata0, rdata1  output  32 each  read data; meaningful only while rvalidN=1.
REQ-012 err0, err1  output  1 each  out-of-range strobe; asserted together with rvalidN, or alone for a rejected write.
REQ-013 mem_addr  output  AW  address to the synchronous data memory.
REQ-014 mem_din  output  32  write data to the memory.
REQ-015 mem_we  output  1  write enable to the memory.
REQ-016 mem_dout  input  32  memory read data, registered; valid the cycle after a read is issued.

Function
REQ-017 At most one of gnt0 and gnt1 shall be 1 in any cycle.
REQ-018 A granted request shall be driven onto mem_addr, mem_din and mem_we in the same cycle.
REQ-019 When no request is granted, mem_we shall be 0.
REQ-020 Round-robin arbitration: a 1-bit priority pointer names the favoured requester.
REQ-021 If only one requester asserts req, it shall be granted regardless of the pointer.
REQ-022 If both requesters assert req, the requester named by the pointer shall be granted.
REQ-023 After any grant to requester i, the pointer shall become 1-i; with no grant, the pointer holds.
REQ-024 Read latency shall be exactly 1 cycle: a read granted in cycle N produces rvalidN=1 in cycle N+1, with rdataN = mem_dout.
REQ-025 A registered response tag (valid, owner, err) shall carry each granted read to cycle N+1.
REQ-026 Back-to-back grants shall be supported with no bubble: one grant per cycle and one response per cycle.
REQ-027 Writes shall produce no rvalid.
REQ-028 An address >= DEPTH shall still be granted but shall not access the memory (mem_we=0).
REQ-029 An out-of-range read shall return rvalid=1, err=1, rdata=0 in cycle N+1.
REQ-030 An out-of-range write shall assert err=1 in cycle N+1 with rvalid=0.
REQ-031 When a write and a read to the same address are granted in consecutive cycles, the read shall return the newly written data; no forwarding is required because the write completes first.
REQ-032 A requester whose req is not granted shall keep req and its payload stable until granted; the arbiter holds no request queue.

Reset
REQ-033 While rst=1, on each clock edge: pointer <- 0, response tag <- invalid.
REQ-034 While rst=1, gnt0, gnt1, mem_we, rvalid0, rvalid1, err0 and err1 shall all be 0.
REQ-035 A read in flight when rst rises shall be dropped with no rvalid.
REQ-036 The first grant after rst falls shall follow REQ-021/REQ-022 with pointer=0.

Structure
REQ-037 The shared package shall hold DEPTH default, the requester-index type and the response-tag struct (valid, owner, err).
REQ-038 The round-robin pick logic shall be one sub-module, rr_pick2, that takes req[1:0] and the pointer and returns the one-hot grant.

Verification
REQ-039 Reset: assert rst with req0=req1=1 -> gnt, mem_we and rvalid all 0; first cycle after release -> gnt0=1.
REQ-040 Contention: req0=req1=1 held for 4 cycles -> grants alternate 0,1,0,1.
REQ-041 Write then read: requester 0 writes 0xDEADBEEF to address 5; requester 1 then reads address 5 -> rvalid1=1 one cycle later with rdata1=0xDEADBEEF.
REQ-042 Out of range: requester 1 reads address 40 -> rvalid1=1, err1=1, rdata1=0, mem_we=0.
REQ-043 Pipelined reads: requester 0 reads addresses 0,1,2 in consecutive cycles -> three consecutive rvalid0 pulses, data in order.
REQ-044 Reset mid-read: rst asserted in the cycle after a read grant -> no rvalid is produced.
